// File: rtl/placement_eval_engine.sv
// Placement-cost evaluator: walks the edge ROM, fetches both endpoint positions
// and accumulates saturating wirelength, hop cost, longest edge and edge counters.
module placement_eval_engine #(
  parameter int EDGE_W   = 10,
  parameter int NODE_W   = 7,
  parameter int DATA_W   = 32,
  parameter int ACC_W    = 32,
  parameter int HOP_LOG2 = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [EDGE_W:0]          n_edge,
  output logic                     edge_re,
  output logic [EDGE_W-1:0]        edge_addr,
  input  logic [NODE_W-1:0]        edge_a,
  input  logic [NODE_W-1:0]        edge_b,
  output logic                     pos_re,
  output logic [NODE_W-1:0]        pos_addr,
  input  logic signed [DATA_W-1:0] pos_x,
  input  logic signed [DATA_W-1:0] pos_y,
  output logic                     busy,
  output logic                     done,
  output logic [ACC_W-1:0]         sum,
  output logic [ACC_W-1:0]         sum_hop,
  output logic [ACC_W-1:0]         max_len,
  output logic [EDGE_W:0]          unplaced,
  output logic [EDGE_W:0]          overlap
);

  localparam int DW2 = DATA_W + 2;
  localparam int CW  = EDGE_W + 1;
  localparam int SW  = ((ACC_W > DW2) ? ACC_W : DW2) + 1;
  localparam logic [DW2-1:0]    HOP_M1    = DW2'((1 << HOP_LOG2) - 1);
  localparam logic [DW2-1:0]    D_ONE     = DW2'(1);
  localparam logic [CW-1:0]     IDX_ONE   = CW'(1);
  localparam logic [ACC_W-1:0]  ACC_MAX_A = '1;
  localparam logic [SW-1:0]     ACC_MAX   = SW'(ACC_MAX_A);
  localparam logic [DATA_W-1:0] NEG_ONE   = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_EDGE, S_RD_A, S_RD_B, S_DIFF, S_ACC, S_DONE
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       n_q, idx_q, unpl_q, ovl_q;
  logic [NODE_W-1:0]   b_q;
  logic [DATA_W-1:0]   ax_q, ay_q;
  logic [DATA_W:0]     dx_q, dy_q;
  logic                unpl_flag_q;
  logic                edge_re_q, pos_re_q, busy_q, done_q;
  logic [EDGE_W-1:0]   edge_addr_q;
  logic [ACC_W-1:0]    sum_q, hop_q, max_q;

  logic [DATA_W:0]     diff_x_s, diff_y_s, dx_d, dy_d;
  logic [DW2-1:0]      d_s, cx_s, cy_s, hop_s, d_m1_s, hop_m1_s;
  logic [SW-1:0]       sum_ext_s, hop_ext_s, d_ext_s;
  logic [ACC_W-1:0]    sum_d, hop_d, max_cand_s, max_d;
  logic [CW-1:0]       idx_nx_s;
  logic [NODE_W-1:0]   pos_addr_s;

  // Edge arithmetic: absolute differences, hop ceilings and saturating sums
  always_comb begin
    diff_x_s = {ax_q[DATA_W-1], ax_q} - {pos_x[DATA_W-1], pos_x};
    diff_y_s = {ay_q[DATA_W-1], ay_q} - {pos_y[DATA_W-1], pos_y};
    dx_d     = diff_x_s[DATA_W] ? -diff_x_s : diff_x_s;
    dy_d     = diff_y_s[DATA_W] ? -diff_y_s : diff_y_s;
    d_s      = {1'b0, dx_q} + {1'b0, dy_q};
    cx_s     = ({1'b0, dx_q} + HOP_M1) >> HOP_LOG2;
    cy_s     = ({1'b0, dy_q} + HOP_M1) >> HOP_LOG2;
    hop_s    = cx_s + cy_s;
    d_m1_s   = (d_s == '0) ? '0 : d_s - D_ONE;
    hop_m1_s = (hop_s == '0) ? '0 : hop_s - D_ONE;
    sum_ext_s = SW'(sum_q) + SW'(d_m1_s);
    hop_ext_s = SW'(hop_q) + SW'(hop_m1_s);
    d_ext_s   = SW'(d_s);
    sum_d      = (sum_ext_s > ACC_MAX) ? ACC_MAX_A : sum_ext_s[ACC_W-1:0];
    hop_d      = (hop_ext_s > ACC_MAX) ? ACC_MAX_A : hop_ext_s[ACC_W-1:0];
    max_cand_s = (d_ext_s > ACC_MAX) ? ACC_MAX_A : d_ext_s[ACC_W-1:0];
    max_d      = (max_cand_s > max_q) ? max_cand_s : max_q;
    idx_nx_s   = idx_q + IDX_ONE;
    // Endpoint a comes straight from the edge ROM, which holds it until the next edge read
    if (state_q == S_RD_B) begin
      pos_addr_s = b_q;
    end else begin
      pos_addr_s = edge_a;
    end
  end

  // Control FSM with registered read strobes, status and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      idx_q       <= '0;
      unpl_q      <= '0;
      ovl_q       <= '0;
      b_q         <= '0;
      ax_q        <= '0;
      ay_q        <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      unpl_flag_q <= 1'b0;
      edge_re_q   <= 1'b0;
      pos_re_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      edge_addr_q <= '0;
      sum_q       <= '0;
      hop_q       <= '0;
      max_q       <= '0;
    end else begin
      edge_re_q <= 1'b0;
      pos_re_q  <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sum_q       <= '0;
            hop_q       <= '0;
            max_q       <= '0;
            unpl_q      <= '0;
            ovl_q       <= '0;
            n_q         <= n_edge;
            idx_q       <= '0;
            edge_addr_q <= '0;
            if (n_edge == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_RD_EDGE;
              edge_re_q <= 1'b1;
              busy_q    <= 1'b1;
            end
          end
        end
        S_RD_EDGE: begin
          pos_re_q <= 1'b1;
          state_q  <= S_RD_A;
        end
        S_RD_A: begin
          b_q      <= edge_b;
          pos_re_q <= 1'b1;
          state_q  <= S_RD_B;
        end
        S_RD_B: begin
          ax_q    <= pos_x;
          ay_q    <= pos_y;
          state_q <= S_DIFF;
        end
        S_DIFF: begin
          dx_q        <= dx_d;
          dy_q        <= dy_d;
          unpl_flag_q <= (ax_q == NEG_ONE) || (pos_x == NEG_ONE);
          state_q     <= S_ACC;
        end
        S_ACC: begin
          if (unpl_flag_q) begin
            unpl_q <= unpl_q + IDX_ONE;
          end else begin
            sum_q <= sum_d;
            hop_q <= hop_d;
            max_q <= max_d;
            if (d_s == '0) begin
              ovl_q <= ovl_q + IDX_ONE;
            end
          end
          idx_q <= idx_nx_s;
          if (idx_nx_s == n_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q     <= S_RD_EDGE;
            edge_re_q   <= 1'b1;
            edge_addr_q <= idx_nx_s[EDGE_W-1:0];
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign edge_re   = edge_re_q;
  assign edge_addr = edge_addr_q;
  assign pos_re    = pos_re_q;
  assign pos_addr  = pos_addr_s;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign sum_hop   = hop_q;
  assign max_len   = max_q;
  assign unplaced  = unpl_q;
  assign overlap   = ovl_q;

endmodule

// File: doc/placement_eval_engine.md
# placement_eval_engine

Parametrised placement-cost evaluator, the next generation of the wirelength evaluation phase in the random-placement flow. After a placer has filled the position RAMs, it walks the edge list and reads both endpoint positions for each edge. It accumulates Manhattan wirelength and hop-cost for a configurable hop reach, tracks the longest edge, and counts unplaced endpoints and overlapping endpoints. It is controlled through a start/done handshake and talks to external edge ROMs and position RAMs.

## Interface
Parameters:
- `EDGE_W`, 10: edge-ROM address width; max edges 2^EDGE_W.
- `NODE_W`, 7: node-ID / position-RAM address width.
- `DATA_W`, 32: signed position data width; −1 = unplaced.
- `ACC_W`, 32: unsigned accumulator width.
- `HOP_LOG2`, 1: hop reach H = 2^HOP_LOG2 cells; 0 gives plain wirelength.

Ports (clock and reset first):
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `n_edge`  in  EDGE_W+1  edge count, sampled with start.
- `edge_re`  out  1  edge ROM read enable.
- `edge_addr`  out  EDGE_W  edge index.
- `edge_a`, `edge_b`  in  NODE_W  edge endpoints.
- `pos_re`  out  1  position RAM read enable (X and Y).
- `pos_addr`  out  NODE_W  node ID.
- `pos_x`, `pos_y`  in  DATA_W signed  node position.
- `busy`  out  1  high from the cycle after start until done.
- `done`  out  1  one-cycle pulse when the results are final.
- `sum`  out  ACC_W  Σ max(d−1,0), where d = |dx|+|dy|.
- `sum_hop`  out  ACC_W  Σ max(⌈dx/H⌉+⌈dy/H⌉−1,0).
- `max_len`  out  ACC_W  largest d seen.
- `unplaced`  out  EDGE_W+1  edges skipped because an endpoint is unplaced.
- `overlap`  out  EDGE_W+1  placed edges with d = 0.

## Operation
- Memory contract: data is valid the cycle after `re` and is held until the next `re`.
- FSM states: IDLE, RD_EDGE, RD_A, RD_B, DIFF, ACC, DONE.
- IDLE:
  - On `start`, clear all accumulators and counters, latch `n_edge`, set idx = 0.
  - If `n_edge` = 0, go to DONE; otherwise go to RD_EDGE.
- RD_EDGE: `edge_re`=1, `edge_addr`=idx; go to RD_A.
- RD_A: latch `edge_b`; `pos_re`=1, `pos_addr`=`edge_a`; go to RD_B.
- RD_B: latch ax/ay; `pos_re`=1, `pos_addr`=latched b; go to DIFF.
- DIFF:
  - Register dx=|ax−bx| and dy=|ay−by|.
  - Set the unplaced flag if ax = −1 or bx = −1 (Y is not checked).
  - Go to ACC.
- ACC:
  - If the unplaced flag is set: `unplaced`++ only; this edge does not update `sum`, `sum_hop`, `max_len` or `overlap`.
  - Otherwise: d = dx+dy; `overlap`++ if d = 0.
  - `sum` += max(d−1,0).
  - `sum_hop` += max(((dx+H−1)>>HOP_LOG2)+((dy+H−1)>>HOP_LOG2)−1, 0).
  - `max_len` = max(`max_len`, d).
  - idx++; go to DONE if idx+1 = latched n_edge, else RD_EDGE.
- DONE: `done`=1 for one cycle, `busy`=0; go to IDLE.
- Arithmetic: differences use DATA_W+1 bits; `sum` and `sum_hop` saturate at 2^ACC_W−1 and never wrap.
- Results hold their values from `done` until the next accepted `start`.
- `start` while busy is ignored, with no effect on the current run.

## Timing
- Reset values: all outputs 0, state IDLE, `busy`=0, `done`=0.
- Reset mid-run aborts the run on the next edge; no `done` is produced.
- Throughput: 5 cycles per edge.
- Latency: with `start` sampled at cycle 0, RD_EDGE is at cycle 1 and `done` is high at cycle 1+5·n_edge. For n_edge = 0, `done` is high at cycle 1.
- `edge_re`/`pos_re` are single-cycle pulses, registered outputs; at most one of them is high per cycle.
- `busy` goes 1 at cycle 1 and 0 in the `done` cycle.

## Test plan
- One edge, a=(0,0), b=(3,2), HOP_LOG2=1 → `sum`=4, `sum_hop`=2, `max_len`=5, `unplaced`=0, `done` at cycle 6.
- Three edges, lengths 1, 4, 7 (dx only), HOP_LOG2=0 → `sum`=9, `sum_hop`=9, `max_len`=7.
- Edge with b.x=−1, plus a placed edge of length 2 → `unplaced`=1, `sum`=1; the unplaced edge leaves `max_len` unchanged.
- Both endpoints at (4,4) → `overlap`=1, `sum`=0, `sum_hop`=0.
- `n_edge`=0 → `done` at cycle 1, all results 0. A second `start` pulse during a run → ignored; `done` fires once.
- Reset asserted at cycle 7 of a 4-edge run → outputs 0 next cycle, no `done`. Then ACC_W=4 with lengths 9+9 → `sum` saturates at 15.
